// File: rtl/abs_twos_pipe.sv
// abs_twos_pipe: two-stage, multi-channel converter between sign-magnitude
// and two's complement, with valid/ready handshakes on both sides.
//   in_mode = 0 : sign-magnitude -> two's complement (SM2C)
//   in_mode = 1 : two's complement -> sign-magnitude (2C2SM)
// Stage 1 registers the raw beat plus the conditional one's complement.
// Stage 2 adds the +1, then registers the result, sign and overflow.
// Optional feature macro: ABS_TWOS_STATS_EN (saturating beat/overflow counters).
module abs_twos_pipe #(
  parameter int unsigned N  = 5,
  parameter int unsigned CH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [CH*N-1:0]   in_data,
  input  logic [CH-1:0]     in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH*N-1:0]   out_data,
  output logic [CH-1:0]     out_sign,
  output logic [CH-1:0]     out_ovf
`ifdef ABS_TWOS_STATS_EN
  ,
  input  logic              stats_clr,
  output logic [15:0]       cnt_beats,
  output logic [15:0]       cnt_ovf
`endif
);

  localparam int unsigned DW = CH * N;

  // Stage 1 state
  logic          s1_valid_q, s1_valid_d;
  logic          s1_mode_q,  s1_mode_d;
  logic [CH-1:0] s1_inv_q,   s1_inv_d;
  logic [DW-1:0] s1_raw_q,   s1_raw_d;
  logic [DW-1:0] s1_x_q,     s1_x_d;

  // Stage 2 (output) state
  logic          s2_valid_q, s2_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [CH-1:0] out_sign_q, out_sign_d;
  logic [CH-1:0] out_ovf_q,  out_ovf_d;

  logic s2_adv;

  // Handshake: stage 2 moves when empty or drained; stage 1 accepts when it can pass on
  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;

  assign out_valid = s2_valid_q;
  assign out_data  = out_data_q;
  assign out_sign  = out_sign_q;
  assign out_ovf   = out_ovf_q;

  // Stage 1 next state: capture beat and invert channels that need negating
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_inv_d   = s1_inv_q;
    s1_raw_d   = s1_raw_q;
    s1_x_d     = s1_x_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (in_valid && in_ready) begin
      s1_mode_d = in_mode;
      s1_raw_d  = in_data;
      for (int k = 0; k < int'(CH); k++) begin
        // SM2C negates when the sign input is set; 2C2SM negates negative values
        s1_inv_d[k]        = in_mode ? in_data[k*N + N - 1] : in_sign[k];
        s1_x_d[k*N +: N]   = in_data[k*N +: N] ^ {N{s1_inv_d[k]}};
      end
    end
  end

  // Stage 2 next state: finish the negation and derive sign/overflow per channel
  always_comb begin
    logic [N-1:0] raw_k;
    logic [N-1:0] sum_k;
    raw_k      = '0;
    sum_k      = '0;
    s2_valid_d = s2_valid_q;
    out_data_d = out_data_q;
    out_sign_d = out_sign_q;
    out_ovf_d  = out_ovf_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (s2_adv && s1_valid_q) begin
      for (int k = 0; k < int'(CH); k++) begin
        raw_k = s1_raw_q[k*N +: N];
        sum_k = s1_x_q[k*N +: N] + N'(s1_inv_q[k]);
        out_data_d[k*N +: N] = sum_k;
        if (s1_mode_q) begin
          out_sign_d[k] = raw_k[N-1];
          out_ovf_d[k]  = 1'b0;
        end else begin
          out_sign_d[k] = sum_k[N-1];
          // Positive magnitudes reaching 2^(N-1), or negative ones beyond it, do not fit
          out_ovf_d[k]  = s1_inv_q[k] ? (raw_k[N-1] && (|raw_k[N-2:0])) : raw_k[N-1];
        end
      end
    end
  end

  // Pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_inv_q   <= '0;
      s1_raw_q   <= '0;
      s1_x_q     <= '0;
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sign_q <= '0;
      out_ovf_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_inv_q   <= s1_inv_d;
      s1_raw_q   <= s1_raw_d;
      s1_x_q     <= s1_x_d;
      s2_valid_q <= s2_valid_d;
      out_data_q <= out_data_d;
      out_sign_q <= out_sign_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

`ifdef ABS_TWOS_STATS_EN
  logic [15:0] cnt_beats_q, cnt_beats_d;
  logic [15:0] cnt_ovf_q,   cnt_ovf_d;
  logic        out_fire;

  assign out_fire  = s2_valid_q && out_ready;
  assign cnt_beats = cnt_beats_q;
  assign cnt_ovf   = cnt_ovf_q;

  // Saturating counters of emitted beats and of emitted beats with any overflow
  always_comb begin
    cnt_beats_d = cnt_beats_q;
    cnt_ovf_d   = cnt_ovf_q;
    if (stats_clr) begin
      cnt_beats_d = '0;
      cnt_ovf_d   = '0;
    end else if (out_fire) begin
      if (cnt_beats_q != 16'hFFFF) begin
        cnt_beats_d = cnt_beats_q + 16'd1;
      end
      if ((|out_ovf_q) && (cnt_ovf_q != 16'hFFFF)) begin
        cnt_ovf_d = cnt_ovf_q + 16'd1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_beats_q <= '0;
      cnt_ovf_q   <= '0;
    end else begin
      cnt_beats_q <= cnt_beats_d;
      cnt_ovf_q   <= cnt_ovf_d;
    end
  end
`endif

endmodule

// File: tb/tb_abs_twos_pipe.sv
// Scoreboard bench for abs_twos_pipe (N=5, CH=2, default build).
// Expected results come from an integer-arithmetic model of the conversion.
module tb_abs_twos_pipe;

  localparam int N  = 5;
  localparam int CH = 2;
  localparam int DW = N * CH;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_mode;
  logic [DW-1:0] in_data;
  logic [CH-1:0] in_sign;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CH-1:0] out_sign;
  logic [CH-1:0] out_ovf;

  typedef struct {
    logic [DW-1:0] data;
    logic [CH-1:0] sign;
    logic [CH-1:0] ovf;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   rdy_mode = 0;   // 0: always 1, 1: 1,0,0,1 pattern, 2: random, 3: always 0
  int   pidx = 0;

  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [CH-1:0] prev_sign;
  logic [CH-1:0] prev_ovf;

  abs_twos_pipe #(.N(N), .CH(CH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .in_sign  (in_sign),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sign (out_sign),
    .out_ovf  (out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: interpret the channel as a signed integer, then re-encode it
  function automatic exp_t model(input logic mode, input logic [DW-1:0] data, input logic [CH-1:0] sign);
    exp_t r;
    for (int k = 0; k < CH; k++) begin
      int mag;
      int v;
      int m;
      mag = int'(data[k*N +: N]);
      if (!mode) begin
        v = sign[k] ? -mag : mag;
        m = ((v % 32) + 32) % 32;
        r.data[k*N +: N] = N'(m);
        r.sign[k] = (m >= 16);
        r.ovf[k]  = (v > 15) || (v < -16);
      end else begin
        v = (mag >= 16) ? mag - 32 : mag;
        r.sign[k] = (v < 0);
        r.data[k*N +: N] = N'((v < 0) ? -v : v);
        r.ovf[k]  = 1'b0;
      end
    end
    return r;
  endfunction

  // out_ready driver
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = (pidx % 4 == 0) || (pidx % 4 == 3);
      2: out_ready = ($urandom_range(3) != 0);
      default: out_ready = 1'b0;
    endcase
    if (rdy_mode == 1) pidx++;
    else pidx = 0;
  end

  // Monitor: ready rule, stall stability, output compare, input capture
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready_rule", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
        check("stall_sign_ovf", 32'({out_sign, out_ovf}), 32'({prev_sign, prev_ovf}));
      end
      if (out_valid && q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else if (out_valid && out_ready) begin
        exp_t e;
        e = q.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_sign", 32'(out_sign), 32'(e.sign));
        check("out_ovf", 32'(out_ovf), 32'(e.ovf));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_sign  = out_sign;
      prev_ovf   = out_ovf;
      if (in_valid && in_ready) q.push_back(model(in_mode, in_data, in_sign));
    end
  end

  // Present one beat and hold it until accepted (call just after a rising edge)
  task automatic send(input logic m, input logic [DW-1:0] d, input logic [CH-1:0] s);
    logic acc;
    int   waits;
    acc   = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    in_sign  = s;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      waits++;
      if (!acc && waits > 200) begin
        check("accept_timeout", 32'(acc), 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rdy_mode = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_data   = '0;
    in_sign   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_regs", 32'({out_data, out_sign, out_ovf}), 32'd0);
    @(posedge clk);
    #1;

    // Latency 2 with a basic SM2C beat
    send(1'b0, {5'd7, 5'd3}, 2'b01);
    @(negedge clk);
    check("lat_edge1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_edge2_valid", 32'(out_valid), 32'd1);
    check("lat_edge2_data", 32'(out_data), 32'(10'b00111_11101));
    check("lat_edge2_ovf", 32'(out_ovf), 32'd0);
    @(posedge clk);
    #1;

    // SM2C boundaries and 2C2SM most-negative / plain negative
    send(1'b0, {5'd16, 5'd16}, 2'b01);
    send(1'b0, {5'd0, 5'd17}, 2'b11);
    send(1'b1, {5'b11101, 5'b10000}, 2'b00);
    send(1'b1, {5'b01111, 5'b00000}, 2'b11);
    drain();

    // Backpressure: six back-to-back beats, alternating modes
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) begin
      send(1'(i % 2), DW'($urandom), CH'($urandom));
    end
    drain();

    // Reset with two beats in flight
    rdy_mode = 3;
    @(posedge clk);
    #1;
    send(1'b0, {5'd9, 5'd20}, 2'b10);
    send(1'b1, {5'd30, 5'd1}, 2'b00);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    rdy_mode = 0;
    repeat (10) @(posedge clk);
    #1;

    // Randomized traffic with random backpressure and gaps
    rdy_mode = 2;
    for (int i = 0; i < 400; i++) begin
      send(1'($urandom), DW'($urandom), CH'($urandom));
      repeat ($urandom_range(2) == 0 ? 1 : 0) @(posedge clk);
      #0;
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
